// File: rtl/hnf_rxreq_arb.sv
// HN-F RXREQ arbiter: picks one position-queue head per cycle (starved > high-QoS > normal,
// round-robin within a class), pops it and holds it in a one-entry valid/ready output register.
package hnf_rxreq_pkg;
  typedef struct packed {
    logic [3:0]  qos;
    logic [6:0]  src_id;
    logic [11:0] txn_id;
    logic [6:0]  opcode;
    logic [31:0] addr;
  } reqflit_t;
endpackage

// Per-requester lost-arbitration counter; flags the requester as starved at the limit.
module hnf_rxreq_wait #(
  parameter int STARVE_LIMIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic arb,
  input  logic valid,
  input  logic win,
  output logic starved
);
  logic [7:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (arb) begin
      if (win || !valid)
        cnt <= '0;
      else if (cnt != 8'(STARVE_LIMIT))
        cnt <= cnt + 8'd1;
    end
  end

  assign starved = valid && (cnt == 8'(STARVE_LIMIT));
endmodule

module hnf_rxreq_arb
  import hnf_rxreq_pkg::*;
#(
  parameter int NUM_RN       = 4,
  parameter int STARVE_LIMIT = 15,
  parameter int QOS_HI       = 12,
  localparam int SRC_W       = (NUM_RN > 1) ? $clog2(NUM_RN) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  reqflit_t [NUM_RN-1:0]   req_flit,
  input  logic     [NUM_RN-1:0]   req_valid,
  output logic     [NUM_RN-1:0]   req_ready,
  output reqflit_t                arb_flit,
  output logic     [SRC_W-1:0]    arb_src,
  output logic                    arb_valid,
  input  logic                    arb_ready
);
  logic [SRC_W-1:0]  rr_ptr, grant_idx;
  logic              load_en, arb_en, found;
  logic [NUM_RN-1:0] starved, hi_qos, cand, win;

  assign load_en = !arb_valid || arb_ready;
  assign arb_en  = !reset && load_en && (|req_valid);

  for (genvar i = 0; i < NUM_RN; i++) begin : g_lane
    assign hi_qos[i] = req_valid[i] && (int'(req_flit[i].qos) >= QOS_HI);
    hnf_rxreq_wait #(.STARVE_LIMIT(STARVE_LIMIT)) u_wait (
      .clock   (clock),
      .reset   (reset),
      .arb     (arb_en),
      .valid   (req_valid[i]),
      .win     (win[i]),
      .starved (starved[i])
    );
  end

  // Highest non-empty class becomes the candidate set for the round-robin scan.
  assign cand = (|starved) ? starved : (|hi_qos) ? hi_qos : req_valid;

  always_comb begin
    int idx;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_RN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_RN) idx = idx - NUM_RN;
      if (!found && cand[idx[SRC_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    win = '0;
    if (arb_en && found) win[grant_idx] = 1'b1;
  end

  assign req_ready = win;

  always_ff @(posedge clock) begin
    if (reset) begin
      arb_valid <= 1'b0;
      arb_flit  <= '0;
      arb_src   <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (arb_en) begin
        arb_valid <= 1'b1;
        arb_flit  <= req_flit[grant_idx];
        arb_src   <= grant_idx;
        rr_ptr    <= (grant_idx == SRC_W'(NUM_RN - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        arb_valid <= 1'b0;
      end
    end
  end
endmodule
